// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard scoreboard for an in-order pipeline with a configurable
// load latency. Loads that have left EX are tracked in a short shift
// pipeline. An ID instruction that reads a register still owed by a load
// younger than the active latency stalls IF/ID and receives an EX bubble.
module load_hazard_scoreboard #(
   parameter int REG_AW  = 5,
   parameter int MAX_LAT = 3,
   parameter int CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              mem_read_EX,
   input  logic [REG_AW-1:0] wb_address_EX,
   input  logic              mux1_sel_signal,
   input  logic              mux2_sel_signal,
   input  logic [REG_AW-1:0] data_address1,
   input  logic [REG_AW-1:0] data_address2,
   input  logic              mem_busywait,
   input  logic              flush_ID,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_lat,
   output logic              hazard_detect_signal,
   output logic [1:0]        stall_state,
   output logic [CNT_W-1:0]  stall_count,
   output logic [3:0]        cur_lat
);

   // Entry k holds the load that left EX k advancing cycles ago.
   localparam int NENT = MAX_LAT - 1;

   localparam logic [1:0] ST_RUN    = 2'b00;
   localparam logic [1:0] ST_HAZARD = 2'b01;
   localparam logic [1:0] ST_FREEZE = 2'b10;

   localparam logic [3:0] MAX_LAT_4 = 4'(MAX_LAT);

   logic [NENT:1]     ent_vld;
   logic [REG_AW-1:0] ent_addr [1:NENT];
   logic              hazard_raw;

   // A source matches only when the operand is actually read from the
   // register file and the register is not the hard-wired zero register.
   function automatic logic src_match(input logic              sel,
                                      input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] cmp);
      return (!sel) && (src == cmp) && (cmp != '0);
   endfunction

   // Requested latency clamped into 1..MAX_LAT; zero keeps the old value.
   function automatic logic [3:0] clamp_lat(input logic [3:0] req,
                                            input logic [3:0] old);
      if (req == 4'd0)
         return old;
      else if (req > MAX_LAT_4)
         return MAX_LAT_4;
      else
         return req;
   endfunction

   // Valid bits shift on advancing cycles and hold while memory stalls.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ent_vld <= '0;
      end else if (!mem_busywait) begin
         ent_vld[1] <= mem_read_EX;
         for (int k = 2; k <= NENT; k++)
            ent_vld[k] <= ent_vld[k-1];
      end
   end

   // Addresses are qualified by the valid bits, so they need no reset.
   always_ff @(posedge CLK) begin
      if (!mem_busywait) begin
         ent_addr[1] <= wb_address_EX;
         for (int k = 2; k <= NENT; k++)
            ent_addr[k] <= ent_addr[k-1];
      end
   end

   // Hazard: EX load or an in-flight load younger than the active latency.
   always_comb begin
      hazard_raw = mem_read_EX &&
                   (src_match(mux1_sel_signal, data_address1, wb_address_EX) ||
                    src_match(mux2_sel_signal, data_address2, wb_address_EX));
      for (int k = 1; k <= NENT; k++) begin
         if (ent_vld[k] && (k < int'(cur_lat)) &&
             (src_match(mux1_sel_signal, data_address1, ent_addr[k]) ||
              src_match(mux2_sel_signal, data_address2, ent_addr[k])))
            hazard_raw = 1'b1;
      end
      hazard_detect_signal = hazard_raw && RESET && !flush_ID && !mem_busywait;
   end

   // Stall classification; a frozen pipeline dominates a load-use hazard.
   always_comb begin
      if (!RESET)
         stall_state = ST_RUN;
      else if (mem_busywait)
         stall_state = ST_FREEZE;
      else if (hazard_detect_signal)
         stall_state = ST_HAZARD;
      else
         stall_state = ST_RUN;
   end

   // Saturating count of hazard cycles.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         stall_count <= '0;
      else if ((stall_state == ST_HAZARD) && (stall_count != '1))
         stall_count <= stall_count + 1'b1;
   end

   // Active latency; a new value applies from the following cycle.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         cur_lat <= 4'd1;
      else if (cfg_we)
         cur_lat <= clamp_lat(cfg_lat, cur_lat);
   end

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed bench for load_hazard_scoreboard. A second instance with a
// 2-bit stall counter shares all inputs to observe counter saturation.
module tb_load_hazard_scoreboard;

   logic        CLK;
   logic        RESET;
   logic        mem_read_EX;
   logic [4:0]  wb_address_EX;
   logic        mux1_sel_signal;
   logic        mux2_sel_signal;
   logic [4:0]  data_address1;
   logic [4:0]  data_address2;
   logic        mem_busywait;
   logic        flush_ID;
   logic        cfg_we;
   logic [3:0]  cfg_lat;
   logic        hz;
   logic [1:0]  st;
   logic [15:0] cnt;
   logic [3:0]  lat;
   logic        hz2;
   logic [1:0]  st2;
   logic [1:0]  cnt2;
   logic [3:0]  lat2;

   int checks   = 0;
   int failures = 0;

   load_hazard_scoreboard dut (
      .CLK(CLK), .RESET(RESET), .mem_read_EX(mem_read_EX),
      .wb_address_EX(wb_address_EX), .mux1_sel_signal(mux1_sel_signal),
      .mux2_sel_signal(mux2_sel_signal), .data_address1(data_address1),
      .data_address2(data_address2), .mem_busywait(mem_busywait),
      .flush_ID(flush_ID), .cfg_we(cfg_we), .cfg_lat(cfg_lat),
      .hazard_detect_signal(hz), .stall_state(st), .stall_count(cnt),
      .cur_lat(lat)
   );

   load_hazard_scoreboard #(.CNT_W(2)) dut_c2 (
      .CLK(CLK), .RESET(RESET), .mem_read_EX(mem_read_EX),
      .wb_address_EX(wb_address_EX), .mux1_sel_signal(mux1_sel_signal),
      .mux2_sel_signal(mux2_sel_signal), .data_address1(data_address1),
      .data_address2(data_address2), .mem_busywait(mem_busywait),
      .flush_ID(flush_ID), .cfg_we(cfg_we), .cfg_lat(cfg_lat),
      .hazard_detect_signal(hz2), .stall_state(st2), .stall_count(cnt2),
      .cur_lat(lat2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      mem_read_EX     = 1'b0;
      wb_address_EX   = 5'd0;
      mux1_sel_signal = 1'b1;
      mux2_sel_signal = 1'b1;
      data_address1   = 5'd0;
      data_address2   = 5'd0;
      mem_busywait    = 1'b0;
      flush_ID        = 1'b0;
      cfg_we          = 1'b0;
      cfg_lat         = 4'd0;
   endtask

   task automatic test_reset();
      mem_read_EX = 1'b1; wb_address_EX = 5'd5;
      mux1_sel_signal = 1'b0; data_address1 = 5'd5;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL reset_hazard: got %0d want 0", hz); end
      checks++; if (st !== 2'b00) begin failures++; $display("FAIL reset_state: got %0d want 0", st); end
      checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", cnt); end
      checks++; if (lat !== 4'd1) begin failures++; $display("FAIL reset_lat: got %0d want 1", lat); end
      checks++; if (lat2 !== 4'd1) begin failures++; $display("FAIL reset_lat_c2: got %0d want 1", lat2); end
      idle();
   endtask

   task automatic test_classic_load_use();
      mem_read_EX = 1'b1; wb_address_EX = 5'd5;
      mux1_sel_signal = 1'b0; data_address1 = 5'd5;
      #1;
      checks++; if (hz !== 1'b1) begin failures++; $display("FAIL l1_hazard: got %0d want 1", hz); end
      checks++; if (st !== 2'b01) begin failures++; $display("FAIL l1_state: got %0d want 1", st); end
      tick();
      checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL l1_count: got %0d want 1", cnt); end
      mem_read_EX = 1'b0;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL l1_bubble_hazard: got %0d want 0", hz); end
      checks++; if (st !== 2'b00) begin failures++; $display("FAIL l1_bubble_state: got %0d want 0", st); end
      tick();
      checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL l1_bubble_count: got %0d want 1", cnt); end
      idle(); tick(); tick();
   endtask

   task automatic test_multicycle_latency();
      cfg_we = 1'b1; cfg_lat = 4'd3;
      tick();
      cfg_we = 1'b0;
      checks++; if (lat !== 4'd3) begin failures++; $display("FAIL cfg3_lat: got %0d want 3", lat); end
      mem_read_EX = 1'b1; wb_address_EX = 5'd7;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL l3_ex_noread: got %0d want 0", hz); end
      tick();
      mem_read_EX = 1'b0; mux1_sel_signal = 1'b0; data_address1 = 5'd7;
      #1;
      checks++; if (hz !== 1'b1) begin failures++; $display("FAIL l3_plus1: got %0d want 1", hz); end
      tick();
      mux1_sel_signal = 1'b1; mux2_sel_signal = 1'b0; data_address2 = 5'd7;
      #1;
      checks++; if (hz !== 1'b1) begin failures++; $display("FAIL l3_plus2: got %0d want 1", hz); end
      tick();
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL l3_plus3: got %0d want 0", hz); end
      checks++; if (cnt !== 16'd3) begin failures++; $display("FAIL l3_count: got %0d want 3", cnt); end
      idle(); tick(); tick();
   endtask

   task automatic test_no_match();
      mem_read_EX = 1'b1; wb_address_EX = 5'd0;
      mux1_sel_signal = 1'b0; data_address1 = 5'd0;
      mux2_sel_signal = 1'b0; data_address2 = 5'd0;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL x0_ex: got %0d want 0", hz); end
      tick();
      mem_read_EX = 1'b0;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL x0_entry: got %0d want 0", hz); end
      tick();
      mem_read_EX = 1'b1; wb_address_EX = 5'd9;
      mux1_sel_signal = 1'b1; data_address1 = 5'd9;
      mux2_sel_signal = 1'b0; data_address2 = 5'd3;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL sel1_ex: got %0d want 0", hz); end
      tick();
      mem_read_EX = 1'b0;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL sel1_entry: got %0d want 0", hz); end
      idle(); tick(); tick();
   endtask

   task automatic test_freeze();
      cfg_we = 1'b1; cfg_lat = 4'd2;
      tick();
      cfg_we = 1'b0;
      checks++; if (lat !== 4'd2) begin failures++; $display("FAIL cfg2_lat: got %0d want 2", lat); end
      mem_read_EX = 1'b1; wb_address_EX = 5'd11;
      tick();
      wb_address_EX = 5'd12;
      mux1_sel_signal = 1'b0; data_address1 = 5'd11;
      mem_busywait = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (hz !== 1'b0) begin failures++; $display("FAIL freeze_hazard[%0d]: got %0d want 0", i, hz); end
         checks++; if (st !== 2'b10) begin failures++; $display("FAIL freeze_state[%0d]: got %0d want 2", i, st); end
         tick();
      end
      checks++; if (cnt !== 16'd3) begin failures++; $display("FAIL freeze_count: got %0d want 3", cnt); end
      mem_busywait = 1'b0; mem_read_EX = 1'b0;
      #1;
      checks++; if (hz !== 1'b1) begin failures++; $display("FAIL release_hazard: got %0d want 1", hz); end
      checks++; if (st !== 2'b01) begin failures++; $display("FAIL release_state: got %0d want 1", st); end
      tick();
      checks++; if (cnt !== 16'd4) begin failures++; $display("FAIL release_count: got %0d want 4", cnt); end
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL l2_beyond: got %0d want 0", hz); end
      idle(); tick(); tick();
   endtask

   task automatic test_flush();
      mem_read_EX = 1'b1; wb_address_EX = 5'd4;
      mux1_sel_signal = 1'b0; data_address1 = 5'd4;
      flush_ID = 1'b1;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL flush_hazard: got %0d want 0", hz); end
      checks++; if (st !== 2'b00) begin failures++; $display("FAIL flush_state: got %0d want 0", st); end
      flush_ID = 1'b0;
      #1;
      checks++; if (hz !== 1'b1) begin failures++; $display("FAIL unflush_hazard: got %0d want 1", hz); end
      idle(); tick(); tick();
   endtask

   task automatic test_cfg_clamp();
      cfg_we = 1'b1; cfg_lat = 4'd0;
      tick();
      checks++; if (lat !== 4'd2) begin failures++; $display("FAIL cfg0_lat: got %0d want 2", lat); end
      cfg_lat = 4'd12;
      tick();
      checks++; if (lat !== 4'd3) begin failures++; $display("FAIL cfg12_lat: got %0d want 3", lat); end
      cfg_lat = 4'd1;
      tick();
      checks++; if (lat !== 4'd1) begin failures++; $display("FAIL cfg1_lat: got %0d want 1", lat); end
      idle();
   endtask

   task automatic test_count_saturation();
      RESET = 1'b0;
      #2;
      RESET = 1'b1;
      checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL sat_clear: got %0d want 0", cnt); end
      checks++; if (cnt2 !== 2'd0) begin failures++; $display("FAIL sat_clear_c2: got %0d want 0", cnt2); end
      mem_read_EX = 1'b1; wb_address_EX = 5'd5;
      mux1_sel_signal = 1'b0; data_address1 = 5'd5;
      for (int i = 1; i <= 5; i++) begin
         #1;
         checks++; if (hz2 !== 1'b1 || st2 !== 2'b01) begin failures++; $display("FAIL sat_c2_hazard[%0d]: got %0d/%0d want 1/1", i, hz2, st2); end
         tick();
         checks++; if (cnt !== 16'(i)) begin failures++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, cnt, i); end
         checks++; if (cnt2 !== 2'((i < 3) ? i : 3)) begin failures++; $display("FAIL sat_count_c2[%0d]: got %0d want %0d", i, cnt2, (i < 3) ? i : 3); end
      end
      idle(); tick();
   endtask

   task automatic test_reset_mid_stall();
      cfg_we = 1'b1; cfg_lat = 4'd3;
      tick();
      cfg_we = 1'b0;
      mem_read_EX = 1'b1; wb_address_EX = 5'd6;
      tick();
      mem_read_EX = 1'b0; mux1_sel_signal = 1'b0; data_address1 = 5'd6;
      tick();
      #1;
      checks++; if (hz !== 1'b1) begin failures++; $display("FAIL prereset_hazard: got %0d want 1", hz); end
      RESET = 1'b0;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL inreset_hazard: got %0d want 0", hz); end
      checks++; if (st !== 2'b00) begin failures++; $display("FAIL inreset_state: got %0d want 0", st); end
      checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL inreset_count: got %0d want 0", cnt); end
      checks++; if (lat !== 4'd1) begin failures++; $display("FAIL inreset_lat: got %0d want 1", lat); end
      RESET = 1'b1;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL postreset_hazard: got %0d want 0", hz); end
      cfg_we = 1'b1; cfg_lat = 4'd3;
      tick();
      cfg_we = 1'b0;
      #1;
      checks++; if (hz !== 1'b0) begin failures++; $display("FAIL postreset_l3_hazard: got %0d want 0", hz); end
      checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL postreset_count: got %0d want 0", cnt); end
      idle(); tick();
   endtask

   initial begin
      idle();
      RESET = 1'b0;
      #12;
      test_reset();
      #1;
      RESET = 1'b1;
      tick();
      test_classic_load_use();
      test_multicycle_latency();
      test_no_match();
      test_freeze();
      test_flush();
      test_cfg_clamp();
      test_count_saturation();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_hazard_scoreboard.md
LOAD_HAZARD_SCOREBOARD -- requirements
Module: load_hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register address width.
REQ-002 SHALL have parameter MAX_LAT, default 3, legal range 2..8: maximum load-use latency in stages.
REQ-003 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-004 SHALL have port CLK  input  1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port RESET  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port mem_read_EX  input  1: the EX instruction is a load.
REQ-007 SHALL have port wb_address_EX  input  REG_AW: load destination register in EX.
REQ-008 SHALL have ports mux1_sel_signal and mux2_sel_signal  input  1 each: 0 means the ID instruction reads register operand 1 or 2 respectively.
REQ-009 SHALL have ports data_address1 and data_address2  input  REG_AW each: source registers of the ID instruction.
REQ-010 SHALL have port mem_busywait  input  1: memory stall; the whole pipeline is frozen.
REQ-011 SHALL have port flush_ID  input  1: the ID instruction is being squashed.
REQ-012 SHALL have port cfg_we  input  1: load-latency configuration write strobe.
REQ-013 SHALL have port cfg_lat  input  4: requested load latency.
REQ-014 SHALL have port hazard_detect_signal  output  1: hold IF/ID and insert an EX bubble.
REQ-015 SHALL have port stall_state  output  2: 00 RUN, 01 HAZARD, 10 FREEZE.
REQ-016 SHALL have port stall_count  output  CNT_W: saturating count of HAZARD cycles.
REQ-017 SHALL have port cur_lat  output  4: active load latency L.

Function
REQ-018 SHALL keep a shift pipeline of MAX_LAT-1 entries (valid bit and address each); entry k holds the load that left EX k advancing cycles ago.
REQ-019 SHALL define an advancing cycle as one where mem_busywait=0.
REQ-020 SHALL, on each advancing edge, load entry 1 with {mem_read_EX, wb_address_EX} and shift entry k into entry k+1; the last entry drops out.
REQ-021 SHALL hold every entry unchanged when mem_busywait=1.
REQ-022 SHALL treat a source as matching when its mux select is 0, its address equals the compared address, and the address is nonzero; x0 never matches.
REQ-023 SHALL assert hazard_detect_signal combinationally when flush_ID=0, mem_busywait=0, and a source matches either the EX load (mem_read_EX=1) or a valid entry k with 1 <= k <= L-1.
REQ-024 SHALL, when L=1, reproduce classic single-cycle load-use detection, with the entries ignored.
REQ-025 SHALL force hazard_detect_signal=0 when flush_ID=1 or mem_busywait=1.
REQ-026 SHALL drive stall_state combinationally: FREEZE if mem_busywait=1, else HAZARD if hazard_detect_signal=1, else RUN.
REQ-027 SHALL increment stall_count by 1 on each edge where stall_state=HAZARD, saturating at 2^CNT_W-1 with no wrap.
REQ-028 SHALL, on a cfg_we edge, latch cur_lat as follows: cfg_lat if 1 <= cfg_lat <= MAX_LAT; MAX_LAT if cfg_lat > MAX_LAT; unchanged if cfg_lat = 0.
REQ-029 SHALL make a new cur_lat take effect from the next cycle; entries already in flight are retained and compared against the new L.
REQ-030 SHALL give precedence to cfg_we over nothing else: counting, shifting and configuration occur in the same edge independently.

Reset
REQ-031 SHALL, while RESET=0, asynchronously clear all entry valid bits, set stall_count=0 and set cur_lat=1.
REQ-032 SHALL, while RESET=0, drive hazard_detect_signal=0 and stall_state=00.
REQ-033 SHALL discard in-flight entries on reset mid-operation; there is no post-reset hazard from pre-reset loads.
REQ-034 SHALL resume normal operation from the first rising edge after RESET deasserts.

Verification
REQ-035 SHALL cover: L=1; EX lw x5 with ID add reading x5 via operand 1 -> hazard=1 for one cycle, stall_count=1; then the EX bubble -> hazard=0.
REQ-036 SHALL cover: cfg_lat=3; lw x7 advances; the ID user of x7 arrives 1 and then 2 cycles later -> hazard=1 on both cycles; arriving 3 cycles later -> hazard=0.
REQ-037 SHALL cover: lw x0, or a source match with mux_sel=1 -> hazard=0 always.
REQ-038 SHALL cover: L=2 with an entry matching and mem_busywait=1 for 4 cycles -> stall_state=FREEZE and hazard=0; the entry is held; on busywait release -> hazard=1.
REQ-039 SHALL cover: cfg_lat=0 -> cur_lat unchanged; cfg_lat=12 -> cur_lat=MAX_LAT; CNT_W=2 with 5 hazard cycles -> stall_count=3.
REQ-040 SHALL cover: RESET low mid-stall with a matching entry -> hazard=0 and stall_count=0 immediately; after release with the ID still reading the register -> hazard=0.
